asrv32_clint: RTL

ASRV32_CLINT -- requirements
Module: asrv32_clint

---
 rtl/asrv32_clint.sv | 129 ++++++++++++
 1 files changed

// File: rtl/asrv32_clint.sv
// Core-local interruptor: memory-mapped msip, mtimecmp and a prescaled 64-bit mtime,
// with sync pulses that keep the core's private mtime/mtimecmp copies up to date.
module asrv32_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_wr_mask,
  input  logic        i_wr_en,
  input  logic        i_rd_en,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  output logic        o_mtime_wr,
  output logic [63:0] o_mtime_din,
  output logic        o_mtimecmp_wr,
  output logic [63:0] o_mtimecmp_din,
  output logic        o_software_interrupt,
  output logic        o_timer_pending
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [15:0] pre_cnt;

  logic        sel;
  logic [2:0]  offset;
  logic        rd_hit;
  logic        wr_hit;
  logic [31:0] byte_mask;
  logic [31:0] cur_word;
  logic [31:0] merged_word;
  logic        msip_we;
  logic        mtimecmp_we;
  logic        mtime_we;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp_next;
  logic [15:0] pre_cnt_next;
  logic        unused_addr_bits;

  assign sel              = (i_addr[31:5] == BASE_ADDR[31:5]);
  assign offset           = i_addr[4:2];
  assign unused_addr_bits = ^i_addr[1:0];

  // Requests are single-cycle strobes with no back-pressure; a selected read is
  // answered by o_rd_valid exactly one cycle later, and o_rd_data holds otherwise.
  assign rd_hit = sel & i_rd_en;
  assign wr_hit = sel & i_wr_en & (|i_wr_mask);

  assign byte_mask = {{8{i_wr_mask[3]}}, {8{i_wr_mask[2]}},
                      {8{i_wr_mask[1]}}, {8{i_wr_mask[0]}}};

  always_comb begin
    cur_word = '0;
    case (offset)
      3'd0:    cur_word = {31'd0, msip};
      3'd2:    cur_word = mtimecmp[31:0];
      3'd3:    cur_word = mtimecmp[63:32];
      3'd4:    cur_word = mtime[31:0];
      3'd5:    cur_word = mtime[63:32];
      default: cur_word = '0;
    endcase
  end

  assign merged_word = (cur_word & ~byte_mask) | (i_wr_data & byte_mask);
  assign msip_we     = wr_hit & (offset == 3'd0);
  assign mtimecmp_we = wr_hit & ((offset == 3'd2) | (offset == 3'd3));
  assign mtime_we    = wr_hit & ((offset == 3'd4) | (offset == 3'd5));

  // A software write to mtime wins over the tick and restarts the prescaler.
  always_comb begin
    mtime_next   = mtime;
    pre_cnt_next = pre_cnt;
    if (mtime_we) begin
      pre_cnt_next = '0;
      if (offset[0]) mtime_next = {merged_word, mtime[31:0]};
      else           mtime_next = {mtime[63:32], merged_word};
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt_next = '0;
      mtime_next   = mtime + 64'd1;
    end else begin
      pre_cnt_next = pre_cnt + 16'd1;
    end
  end

  always_comb begin
    mtimecmp_next = mtimecmp;
    if (mtimecmp_we) begin
      if (offset[0]) mtimecmp_next = {merged_word, mtimecmp[31:0]};
      else           mtimecmp_next = {mtimecmp[63:32], merged_word};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime           <= '0;
      pre_cnt         <= '0;
      mtimecmp        <= '1;
      msip            <= 1'b0;
      o_rd_data       <= '0;
      o_rd_valid      <= 1'b0;
      o_mtime_wr      <= 1'b0;
      o_mtime_din     <= '0;
      o_mtimecmp_wr   <= 1'b0;
      o_mtimecmp_din  <= '1;
      o_timer_pending <= 1'b0;
    end else begin
      mtime         <= mtime_next;
      pre_cnt       <= pre_cnt_next;
      mtimecmp      <= mtimecmp_next;
      if (msip_we) msip <= merged_word[0];
      o_rd_valid    <= rd_hit;
      if (rd_hit) o_rd_data <= cur_word;
      o_mtime_wr    <= mtime_we;
      if (mtime_we) o_mtime_din <= mtime_next;
      o_mtimecmp_wr <= mtimecmp_we;
      if (mtimecmp_we) o_mtimecmp_din <= mtimecmp_next;
      o_timer_pending <= (mtime_next >= mtimecmp_next);
    end
  end

  assign o_software_interrupt = msip;

endmodule
